cmd_dispatch_sched: RTL and testbench

Sits directly downstream of the SPI instruction/data buffer. Captures each decoded command (8-bit opcode plus 64-bit payload, already classified as camwrite, read or mem) into a small FIFO. Issues the commands one at a time, in order, to the matching execution unit over a req/ack/done handshake. Detects queue overflow, malformed class strobes and stalled units, and reports each as a sticky error flag.

---
 rtl/cmd_dispatch_sched.sv | 189 ++++++++++++++++++
 tb/tb_cmd_dispatch_sched.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatch_sched.sv
// Command dispatch scheduler: queues classified commands from the SPI buffer
// in a small FIFO and issues them in order, one at a time, to the matching
// execution unit over a req/ack/done handshake. Overflow, multi-strobe and
// unit-stall conditions are reported as sticky error flags.
module cmd_dispatch_sched #(
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 11
) (
  input  logic              sysClk,
  input  logic              reset,
  input  logic [7:0]        instruction,
  input  logic [63:0]       data,
  input  logic              valid_buffer_for_camwrite,
  input  logic              valid_buffer_for_read,
  input  logic              valid_buffer_for_mem,
  output logic              cam_req,
  output logic              rd_req,
  output logic              mem_req,
  input  logic              cam_ack,
  input  logic              rd_ack,
  input  logic              mem_ack,
  input  logic              cam_done,
  input  logic              rd_done,
  input  logic              mem_done,
  output logic [7:0]        cmd_instruction,
  output logic [63:0]       cmd_data,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow_err,
  output logic              illegal_err,
  output logic              timeout_err,
  input  logic              err_clear
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CLS_CAM = 2'd0;
  localparam logic [1:0] CLS_RD  = 2'd1;
  localparam logic [1:0] CLS_MEM = 2'd2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [1:0]         fifo_cls [DEPTH];
  logic [7:0]         fifo_ins [DEPTH];
  logic [63:0]        fifo_dat [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [1:0]         strobe_cnt;
  logic [1:0]         in_cls;
  logic [1:0]         cur_cls;
  logic [TMR_W-1:0]   timer;
  logic               one_strobe, multi_strobe, fifo_full;
  logic               push, pop, ovf_set, tmo_set;
  logic               sel_ack, sel_done;

  assign strobe_cnt   = {1'b0, valid_buffer_for_camwrite} + {1'b0, valid_buffer_for_read}
                      + {1'b0, valid_buffer_for_mem};
  assign one_strobe   = (strobe_cnt == 2'd1);
  assign multi_strobe = (strobe_cnt >= 2'd2);
  assign fifo_full    = (fifo_count == FULL_CNT);
  assign pop          = (state == S_IDLE) && (fifo_count != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push         = one_strobe && (!fifo_full || pop);
  assign ovf_set      = one_strobe && fifo_full && !pop;
  assign busy         = (state != S_IDLE) || (fifo_count != '0);

  // Encode the class of the single active strobe.
  always_comb begin
    in_cls = CLS_CAM;
    if (valid_buffer_for_read)    in_cls = CLS_RD;
    else if (valid_buffer_for_mem) in_cls = CLS_MEM;
  end

  // Route the handshake of the selected unit; other units are ignored.
  always_comb begin
    sel_ack  = 1'b0;
    sel_done = 1'b0;
    case (cur_cls)
      CLS_CAM: begin sel_ack = cam_ack; sel_done = cam_done; end
      CLS_RD:  begin sel_ack = rd_ack;  sel_done = rd_done;  end
      CLS_MEM: begin sel_ack = mem_ack; sel_done = mem_done; end
      default: begin sel_ack = 1'b0;    sel_done = 1'b0;     end
    endcase
  end

  // FIFO payload storage; contents are only meaningful below fifo_count.
  always_ff @(posedge sysClk) begin
    if (push) begin
      fifo_cls[wr_ptr] <= in_cls;
      fifo_ins[wr_ptr] <= instruction;
      fifo_dat[wr_ptr] <= data;
    end
  end

  // FIFO pointers and explicit occupancy count.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state, request lines and timeout detection.
  always_comb begin
    state_nxt = state;
    cam_req   = 1'b0;
    rd_req    = 1'b0;
    mem_req   = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) state_nxt = S_REQ;
      end
      S_REQ: begin
        cam_req = (cur_cls == CLS_CAM);
        rd_req  = (cur_cls == CLS_RD);
        mem_req = (cur_cls == CLS_MEM);
        if (sel_ack) begin
          state_nxt = sel_done ? S_IDLE : S_WAIT;
        end else if (timer == TMR_LAST) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (sel_done) begin
          state_nxt = S_IDLE;
        end else if (timer == TMR_LAST) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the popped command; it stays visible until the next pop.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      cmd_instruction <= '0;
      cmd_data        <= '0;
      cur_cls         <= CLS_CAM;
    end else if (pop) begin
      cmd_instruction <= fifo_ins[rd_ptr];
      cmd_data        <= fifo_dat[rd_ptr];
      cur_cls         <= fifo_cls[rd_ptr];
    end
  end

  // Cycles since the command was issued.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset)                 timer <= '0;
    else if (pop)              timer <= '0;
    else if (state != S_IDLE)  timer <= timer + TMR_W'(1);
  end

  // Sticky errors; a new error wins over a same-cycle clear.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      overflow_err <= 1'b0;
      illegal_err  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      overflow_err <= ovf_set      | (overflow_err & ~err_clear);
      illegal_err  <= multi_strobe | (illegal_err  & ~err_clear);
      timeout_err  <= tmo_set      | (timeout_err  & ~err_clear);
    end
  end

endmodule

// File: tb/tb_cmd_dispatch_sched.sv
// Testbench for cmd_dispatch_sched: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based transaction model.
module tb_cmd_dispatch_sched;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int TMO   = 16;
  localparam int TMR_W = 5;

  logic             sysClk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       instruction = '0;
  logic [63:0]      data = '0;
  logic             valid_buffer_for_camwrite = 1'b0;
  logic             valid_buffer_for_read = 1'b0;
  logic             valid_buffer_for_mem = 1'b0;
  logic             cam_req, rd_req, mem_req;
  logic             cam_ack = 1'b0, rd_ack = 1'b0, mem_ack = 1'b0;
  logic             cam_done = 1'b0, rd_done = 1'b0, mem_done = 1'b0;
  logic [7:0]       cmd_instruction;
  logic [63:0]      cmd_data;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow_err, illegal_err, timeout_err;
  logic             err_clear = 1'b0;

  cmd_dispatch_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO), .TMR_W(TMR_W)) dut (
    .sysClk(sysClk), .reset(reset), .instruction(instruction), .data(data),
    .valid_buffer_for_camwrite(valid_buffer_for_camwrite),
    .valid_buffer_for_read(valid_buffer_for_read),
    .valid_buffer_for_mem(valid_buffer_for_mem),
    .cam_req(cam_req), .rd_req(rd_req), .mem_req(mem_req),
    .cam_ack(cam_ack), .rd_ack(rd_ack), .mem_ack(mem_ack),
    .cam_done(cam_done), .rd_done(rd_done), .mem_done(mem_done),
    .cmd_instruction(cmd_instruction), .cmd_data(cmd_data), .busy(busy),
    .fifo_count(fifo_count), .overflow_err(overflow_err), .illegal_err(illegal_err),
    .timeout_err(timeout_err), .err_clear(err_clear)
  );

  always #5 sysClk = ~sysClk;

  typedef struct {
    logic [1:0]  cls;
    logic [7:0]  ins;
    logic [63:0] dat;
    int          ack_dly;
    int          done_dly;
  } cmd_t;

  // Transaction model: phase 0 idle, 1 requesting, 2 waiting for done.
  cmd_t        m_q[$];
  cmd_t        m_cur;
  int          m_phase = 0;
  int          m_t = 0;
  logic [7:0]  m_ins = '0;
  logic [63:0] m_dat = '0;
  bit          m_ovf = 0, m_ill = 0, m_tmo = 0;
  int          m_done_cnt = 0;

  int plan_ack = 0, plan_done = 0;
  bit hold = 0, noise = 0;
  int checks = 0, failures = 0;

  logic [81:0] act_vec;
  assign act_vec = {cam_req, rd_req, mem_req, busy, fifo_count, overflow_err, illegal_err,
                    timeout_err, cmd_instruction, cmd_data};

  function automatic logic [81:0] exp_vec();
    logic [2:0] r;
    logic       b;
    r = 3'b000;
    if (m_phase == 1) r = 3'b100 >> m_cur.cls;
    b = (m_phase != 0) || (m_q.size() != 0);
    return {r, b, CNT_W'(m_q.size()), m_ovf, m_ill, m_tmo, m_ins, m_dat};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_t = 0; m_ins = '0; m_dat = '0;
    m_ovf = 0; m_ill = 0; m_tmo = 0;
  endtask

  task automatic model_step(input logic [2:0] a, input logic [2:0] d);
    int   n, told;
    bit   pop, full, tmo;
    cmd_t c;
    n    = int'(valid_buffer_for_camwrite) + int'(valid_buffer_for_read) + int'(valid_buffer_for_mem);
    pop  = (m_phase == 0) && (m_q.size() > 0);
    full = (m_q.size() == DEPTH);
    tmo  = 0;
    told = m_t;
    if (m_phase == 0) begin
      if (pop) begin
        m_cur = m_q.pop_front();
        m_ins = m_cur.ins; m_dat = m_cur.dat;
        m_phase = 1; m_t = 0;
      end
    end else begin
      m_t = m_t + 1;
      if (m_phase == 1 && a[m_cur.cls]) begin
        if (d[m_cur.cls]) begin m_phase = 0; m_done_cnt++; end
        else m_phase = 2;
      end else if (m_phase == 2 && d[m_cur.cls]) begin
        m_phase = 0; m_done_cnt++;
      end else if (told == TMO - 1) begin
        m_phase = 0; tmo = 1;
      end
    end
    if (n == 1 && (!full || pop)) begin
      c.cls = valid_buffer_for_camwrite ? 2'd0 : (valid_buffer_for_read ? 2'd1 : 2'd2);
      c.ins = instruction; c.dat = data;
      c.ack_dly = plan_ack; c.done_dly = plan_done;
      m_q.push_back(c);
    end
    m_ill = (n >= 2) || (m_ill && !err_clear);
    m_ovf = (n == 1 && full && !pop) || (m_ovf && !err_clear);
    m_tmo = tmo || (m_tmo && !err_clear);
  endtask

  // One clock: unit responders act on the model's view, model advances, DUT clocks.
  task automatic cycle();
    logic [2:0] a, d;
    a = '0; d = '0;
    if (m_phase == 1 && !hold && m_t >= m_cur.ack_dly) begin
      a[m_cur.cls] = 1'b1;
      if (m_t >= m_cur.done_dly) d[m_cur.cls] = 1'b1;
    end
    if (m_phase == 2 && !hold && m_t >= m_cur.done_dly) d[m_cur.cls] = 1'b1;
    if (noise) begin
      for (int c = 0; c < 3; c++) begin
        if (m_phase == 0 || c != int'(m_cur.cls)) begin
          a[c] = a[c] | ($urandom_range(0, 3) == 0);
          d[c] = d[c] | ($urandom_range(0, 3) == 0);
        end else if (m_phase == 1 && !a[c]) begin
          d[c] = d[c] | ($urandom_range(0, 2) == 0);
        end
      end
    end
    cam_ack = a[0]; rd_ack = a[1]; mem_ack = a[2];
    cam_done = d[0]; rd_done = d[1]; mem_done = d[2];
    model_step(a, d);
    @(posedge sysClk);
    @(negedge sysClk);
    valid_buffer_for_camwrite = 1'b0; valid_buffer_for_read = 1'b0; valid_buffer_for_mem = 1'b0;
    err_clear = 1'b0;
    cam_ack = 1'b0; rd_ack = 1'b0; mem_ack = 1'b0;
    cam_done = 1'b0; rd_done = 1'b0; mem_done = 1'b0;
  endtask

  task automatic strobe(input int cls, input logic [7:0] ins, input logic [63:0] dat);
    instruction = ins; data = dat;
    valid_buffer_for_camwrite = (cls == 0);
    valid_buffer_for_read     = (cls == 1);
    valid_buffer_for_mem      = (cls == 2);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge sysClk);
    checks++;
    if (act_vec !== 82'd0) begin
      failures++; $display("FAIL reset_state: got %h expected 0", act_vec);
    end
    reset = 1'b0;
    model_reset();
    cycle();
    checks++;
    if (act_vec !== exp_vec()) begin
      failures++; $display("FAIL reset_idle: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_single_read();
    int req_cycles;
    plan_ack = 3; plan_done = 6;
    strobe(1, 8'h02, 64'h1122334455667788);
    cycle();
    checks++;
    if (fifo_count !== 3'd1 || rd_req !== 1'b0) begin
      failures++; $display("FAIL read_queued: got cnt=%0d rd_req=%b expected cnt=1 rd_req=0", fifo_count, rd_req);
    end
    cycle();
    checks++;
    if ({cam_req, rd_req, mem_req} !== 3'b010 || cmd_instruction !== 8'h02 || cmd_data !== 64'h1122334455667788) begin
      failures++; $display("FAIL read_issue: got req=%b ins=%h dat=%h", {cam_req, rd_req, mem_req}, cmd_instruction, cmd_data);
    end
    req_cycles = 1;
    for (int i = 0; i < 30 && (m_phase != 0 || m_q.size() != 0); i++) begin
      cycle();
      if (rd_req === 1'b1) req_cycles++;
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++; $display("FAIL read_seq cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (req_cycles != 4 || busy !== 1'b0 || {overflow_err, illegal_err, timeout_err} !== 3'b000
        || cmd_instruction !== 8'h02) begin
      failures++; $display("FAIL read_done: got req_cycles=%0d busy=%b errs=%b expected 4 0 000",
                           req_cycles, busy, {overflow_err, illegal_err, timeout_err});
    end
  endtask

  task automatic test_ordering();
    int       seq[$];
    logic [2:0] prev, cur;
    int       peak;
    bit       overlap;
    plan_ack = 2; plan_done = 2;
    prev = 3'b000; peak = 0; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) strobe(0, 8'h01, 64'hA);
      if (i == 1) strobe(2, 8'h07, 64'hB);
      if (i == 2) strobe(1, 8'h00, 64'hC);
      cycle();
      cur = {cam_req, rd_req, mem_req};
      if ($countones(cur) > 1) overlap = 1;
      if (cur != 3'b000 && prev == 3'b000) seq.push_back(cur == 3'b100 ? 0 : (cur == 3'b010 ? 1 : 2));
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      prev = cur;
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++; $display("FAIL order_seq cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (seq.size() != 3 || seq[0] != 0 || seq[1] != 2 || seq[2] != 1 || overlap || peak != 2) begin
      failures++; $display("FAIL order_summary: got issues=%0d overlap=%0d peak=%0d expected cam,mem,rd 0 2",
                           seq.size(), overlap, peak);
    end
  endtask

  task automatic test_overflow();
    int  rises;
    bit  prev;
    hold = 1; plan_ack = 0; plan_done = 0;
    rises = 0; prev = 0;
    for (int i = 0; i < 6; i++) begin
      strobe(0, 8'(8'h10 + i), 64'(i));
      cycle();
      if (cam_req && !prev) rises++;
      prev = cam_req;
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++; $display("FAIL ovf_fill cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (fifo_count !== 3'd4 || overflow_err !== 1'b1 || cam_req !== 1'b1) begin
      failures++; $display("FAIL ovf_state: got cnt=%0d ovf=%b req=%b expected 4 1 1", fifo_count, overflow_err, cam_req);
    end
    err_clear = 1'b1;
    cycle();
    checks++;
    if (overflow_err !== 1'b0) begin
      failures++; $display("FAIL ovf_clear: got %b expected 0", overflow_err);
    end
    hold = 0;
    for (int i = 0; i < 10 && !(m_phase == 0 && m_q.size() == DEPTH); i++) begin
      cycle();
      if (cam_req && !prev) rises++;
      prev = cam_req;
    end
    // Full and idle: this push coincides with a pop, so it must be accepted.
    strobe(0, 8'h55, 64'h55);
    cycle();
    if (cam_req && !prev) rises++;
    prev = cam_req;
    checks++;
    if (fifo_count !== 3'd4 || overflow_err !== 1'b0 || cam_req !== 1'b1) begin
      failures++; $display("FAIL push_pop_full: got cnt=%0d ovf=%b req=%b expected 4 0 1", fifo_count, overflow_err, cam_req);
    end
    for (int i = 0; i < 40 && (m_phase != 0 || m_q.size() != 0); i++) begin
      cycle();
      if (cam_req && !prev) rises++;
      prev = cam_req;
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++; $display("FAIL ovf_drain cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    // 5 survivors of the 6-strobe burst plus the one pushed while full.
    checks++;
    if (rises != 6 || busy !== 1'b0 || cmd_instruction !== 8'h55) begin
      failures++; $display("FAIL ovf_completions: got %0d issued busy=%b last=%h expected 6 0 55", rises, busy, cmd_instruction);
    end
  endtask

  task automatic test_timeout();
    int mem_cycles, rd_rises;
    bit prev;
    mem_cycles = 0; rd_rises = 0; prev = 0;
    plan_ack = 1000; plan_done = 1000;
    strobe(2, 8'h33, 64'hDEAD);
    cycle();
    plan_ack = 1; plan_done = 2;
    strobe(1, 8'h44, 64'hBEEF);
    for (int i = 0; i < 60 && (i == 0 || m_phase != 0 || m_q.size() != 0); i++) begin
      cycle();
      if (mem_req) mem_cycles++;
      if (rd_req && !prev) rd_rises++;
      prev = rd_req;
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++; $display("FAIL tmo_seq cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (mem_cycles != TMO || timeout_err !== 1'b1 || rd_rises != 1 || cmd_instruction !== 8'h44) begin
      failures++; $display("FAIL tmo_result: got mem_req_cycles=%0d tmo=%b rd_issues=%0d expected 16 1 1",
                           mem_cycles, timeout_err, rd_rises);
    end
    err_clear = 1'b1;
    cycle();
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++; $display("FAIL tmo_clear: got %b expected 0", timeout_err);
    end
  endtask

  task automatic test_illegal();
    instruction = 8'h66; data = 64'h66;
    valid_buffer_for_read = 1'b1; valid_buffer_for_mem = 1'b1;
    cycle();
    checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b0 || illegal_err !== 1'b1) begin
      failures++; $display("FAIL illegal_drop: got cnt=%0d busy=%b ill=%b expected 0 0 1", fifo_count, busy, illegal_err);
    end
    valid_buffer_for_camwrite = 1'b1; valid_buffer_for_read = 1'b1; err_clear = 1'b1;
    cycle();
    checks++;
    if (illegal_err !== 1'b1 || act_vec !== exp_vec()) begin
      failures++; $display("FAIL illegal_set_wins: got ill=%b expected 1", illegal_err);
    end
    err_clear = 1'b1;
    cycle();
    checks++;
    if (illegal_err !== 1'b0) begin
      failures++; $display("FAIL illegal_clear: got %b expected 0", illegal_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit any_req;
    plan_ack = 0; plan_done = 1000;
    strobe(1, 8'h77, 64'h77);
    cycle();
    plan_ack = 0; plan_done = 0;
    strobe(0, 8'h78, 64'h78);
    cycle();
    strobe(0, 8'h79, 64'h79);
    cycle();
    checks++;
    if (act_vec !== exp_vec() || fifo_count !== 3'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL rst_setup: got %h expected %h", act_vec, exp_vec());
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (act_vec !== 82'd0) begin
      failures++; $display("FAIL rst_async: got %h expected 0", act_vec);
    end
    model_reset();
    @(negedge sysClk);
    reset = 1'b0;
    any_req = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (cam_req || rd_req || mem_req) any_req = 1;
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++; $display("FAIL rst_after cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (any_req) begin
      failures++; $display("FAIL rst_no_req: got a request after reset, expected none");
    end
  endtask

  task automatic test_random();
    int r;
    noise = 1;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      plan_ack  = $urandom_range(0, 4);
      plan_done = ($urandom_range(0, 9) == 0) ? 30 : plan_ack + $urandom_range(0, 4);
      instruction = 8'($urandom);
      data = {$urandom, $urandom};
      if (r < 30) begin
        strobe($urandom_range(0, 2), instruction, data);
      end else if (r < 34) begin
        valid_buffer_for_camwrite = 1'($urandom);
        valid_buffer_for_read = 1'b1;
        valid_buffer_for_mem = 1'($urandom);
        if (!valid_buffer_for_camwrite && !valid_buffer_for_mem) valid_buffer_for_mem = 1'b1;
      end
      err_clear = ($urandom_range(0, 19) == 0);
      cycle();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++; $display("FAIL random cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    noise = 0;
    for (int i = 0; i < 200 && (m_phase != 0 || m_q.size() != 0); i++) begin
      cycle();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++; $display("FAIL random_drain cyc%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_ordering();
    test_overflow();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
